// File: rtl/image_stream_sender.sv
`default_nettype none
// ============================================================================
// Module   : image_stream_sender
// Brief    : Streams a decimated frame-buffer image over an 8N1 UART with a
//            sync word, image size, 12..16-bit pixels and an XOR checksum.
// Revision : 1.0
// ============================================================================
module image_stream_sender #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int DECIM      = 2,
    parameter int PIXEL_BITS = 12,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    localparam int ADDR_W       = $clog2(IMG_W * IMG_H),
    localparam int OW           = IMG_W / DECIM,
    localparam int OH           = IMG_H / DECIM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PIXEL_BITS-1:0] pixel,
    output logic [ADDR_W-1:0]     address,
    output logic                  uart_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_DIMS   = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_PIX_HI = 3'd4;
    localparam logic [2:0] S_PIX_LO = 3'd5;
    localparam logic [2:0] S_CSUM   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam int AW1 = ADDR_W + 1;
    localparam int BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0]  c_BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  c_BAUD_PENULT = BW'(CLKS_PER_BIT - 2);
    localparam logic [15:0]    c_OW          = 16'(OW);
    localparam logic [15:0]    c_OH          = 16'(OH);
    localparam logic [AW1-1:0] c_X_LAST      = AW1'(IMG_W - DECIM);
    localparam logic [AW1-1:0] c_Y_LAST      = AW1'(IMG_H - DECIM);
    localparam logic [AW1-1:0] c_STEP        = AW1'(DECIM);
    localparam logic [AW1-1:0] c_ROW_STEP    = AW1'(IMG_W * DECIM);

    logic [2:0]            r_state;
    logic [1:0]            r_cnt;
    logic                  r_phase;
    logic                  r_last;
    logic [AW1-1:0]        r_x;
    logic [AW1-1:0]        r_y;
    logic [AW1-1:0]        r_base;
    logic [PIXEL_BITS-1:0] r_pix;
    logic [7:0]            r_byte;
    logic [7:0]            r_csum;
    logic [3:0]            r_bit;
    logic [BW-1:0]         r_baud;

    logic                  w_byte_end;
    logic                  w_load;
    logic                  w_csum_en;
    logic [7:0]            w_next_byte;
    logic [ADDR_W-1:0]     w_cur_addr;

    assign w_byte_end = (r_baud == c_BAUD_LAST) && (r_bit == 4'd9);
    assign w_cur_addr = ADDR_W'(r_base + r_x);

    // The state names the byte that is loaded when the byte on the line ends.
    always_comb begin
        w_next_byte = 8'h00;
        w_csum_en   = 1'b1;
        case (r_state)
            S_SYNC: begin
                w_next_byte = (r_cnt == 2'd0) ? 8'h5A : c_OW[15:8];
                w_csum_en   = (r_cnt != 2'd0);
            end
            S_DIMS: begin
                case (r_cnt)
                    2'd0:    w_next_byte = c_OW[7:0];
                    2'd1:    w_next_byte = c_OH[15:8];
                    default: w_next_byte = c_OH[7:0];
                endcase
            end
            S_PIX_HI: w_next_byte = 8'(r_pix >> 8);
            S_PIX_LO: w_next_byte = r_pix[7:0];
            S_CSUM: begin
                w_next_byte = r_csum;
                w_csum_en   = 1'b0;
            end
            default: w_csum_en = 1'b0;
        endcase
    end

    assign w_load = w_byte_end &&
                    ((r_state == S_SYNC) || (r_state == S_DIMS) ||
                     (r_state == S_PIX_HI) || (r_state == S_PIX_LO) ||
                     ((r_state == S_CSUM) && (r_cnt == 2'd0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_last     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_base     <= '0;
            r_pix      <= '0;
            r_byte     <= '0;
            r_csum     <= '0;
            r_bit      <= '0;
            r_baud     <= '0;
            address    <= '0;
            uart_out   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if ((r_state != S_IDLE) && (r_state != S_DONE)) begin
                if (r_baud == c_BAUD_LAST) begin
                    r_baud   <= '0;
                    r_bit    <= r_bit + 4'd1;
                    uart_out <= (r_bit >= 4'd8) ? 1'b1 : r_byte[r_bit[2:0]];
                end else begin
                    r_baud <= r_baud + BW'(1);
                end
            end

            if (w_load) begin
                r_byte   <= w_next_byte;
                r_bit    <= '0;
                r_baud   <= '0;
                uart_out <= 1'b0;
                if (w_csum_en) r_csum <= r_csum ^ w_next_byte;
            end

            case (r_state)
                S_IDLE: if (start) begin
                    r_state  <= S_SYNC;
                    busy     <= 1'b1;
                    r_byte   <= 8'hA5;
                    r_bit    <= '0;
                    r_baud   <= '0;
                    uart_out <= 1'b0;
                    r_csum   <= '0;
                    r_cnt    <= '0;
                    r_x      <= '0;
                    r_y      <= '0;
                    r_base   <= '0;
                end
                S_SYNC: if (w_load) begin
                    r_cnt <= (r_cnt == 2'd0) ? 2'd1 : 2'd0;
                    if (r_cnt != 2'd0) r_state <= S_DIMS;
                end
                S_DIMS: if (w_load) begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd2) begin
                        r_state <= S_FETCH;
                        r_phase <= 1'b0;
                        address <= w_cur_addr;
                    end
                end
                S_FETCH: begin
                    // Phase 0 covers the one-clock frame-buffer read latency.
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_pix   <= pixel;
                        r_last  <= (r_x == c_X_LAST) && (r_y == c_Y_LAST);
                        r_state <= S_PIX_HI;
                        if (r_x == c_X_LAST) begin
                            r_x    <= '0;
                            r_y    <= r_y + c_STEP;
                            r_base <= r_base + c_ROW_STEP;
                        end else begin
                            r_x <= r_x + c_STEP;
                        end
                    end
                end
                S_PIX_HI: if (w_load) r_state <= S_PIX_LO;
                S_PIX_LO: if (w_load) begin
                    if (r_last) begin
                        r_state <= S_CSUM;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_FETCH;
                        r_phase <= 1'b0;
                        address <= w_cur_addr;
                    end
                end
                S_CSUM: begin
                    // Leave one clock early so DONE lands as the final stop bit ends.
                    if (w_load) begin
                        r_cnt <= 2'd1;
                    end else if ((r_cnt == 2'd1) && (r_bit == 4'd9) &&
                                 (r_baud == c_BAUD_PENULT)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
